// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: hazard-unit control, opcode constants, latch FSM.
// Types only; adds no logic or latency.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      PIPE_ENABLE = 2'd0,
      PIPE_STALL  = 2'd1,
      PIPE_FLUSH  = 2'd2
   } pipe_state_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LIVE  = 2'd1,
      HELD  = 2'd2
   } pipe_fsm_t;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;
   typedef logic [5:0]  opcode_t;
   typedef logic [5:0]  funct_t;

   localparam opcode_t RTYPE = 6'h00;
   localparam opcode_t JAL   = 6'h03;
   localparam opcode_t LW    = 6'h23;
   localparam funct_t  JR    = 6'h08;

   localparam regbits_t RA_REG = 5'd31;

endpackage

// File: rtl/pipe_fields_decode.sv
// Register-field decode of a latched instruction for hazard detection.
// Purely combinational (0 cycles); no flow control.
module pipe_fields_decode
   import cpu_types_pkg::*;
(
   input  word_t    instr,
   input  logic     valid,
   output regbits_t rs,
   output regbits_t rt,
   output regbits_t wsel,
   output logic     regwr
);

   opcode_t opcode;
   funct_t  funct;
   logic    writes;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];

   always_comb begin
      wsel = instr[20:16];
      if (opcode == RTYPE)
         wsel = instr[15:11];
      else if (opcode == JAL)
         wsel = RA_REG;
   end

   always_comb begin
      writes = 1'b0;
      if (opcode == RTYPE && funct != JR)
         writes = 1'b1;
      else if (opcode >= 6'h08 && opcode <= 6'h0F)
         writes = 1'b1;
      else if (opcode == LW || opcode == JAL)
         writes = 1'b1;
   end

   // $zero never creates a dependence, so a write to it is reported as no write
   assign regwr = valid & writes & (wsel != 5'd0);

endmodule

// File: rtl/pipe_latch.sv
// Stage-boundary pipeline register: 1-cycle latch on ENABLE, hold on STALL, bubble on FLUSH.
// Optional PIPE_LATCH_PERF_EN adds stall/flush performance counters.
module pipe_latch
   import cpu_types_pkg::*;
#(
   parameter int WIDTH       = 64,
   parameter int STALL_LIMIT = 16
)(
   input  logic             CLK,
   input  logic             nRST,
   input  logic [1:0]       state,
   input  logic [31:0]      din_instr,
   input  logic [WIDTH-1:0] din_data,
   input  logic             din_valid,
   output logic [31:0]      dout_instr,
   output logic [WIDTH-1:0] dout_data,
   output logic             dout_valid,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       wsel,
   output logic             regwr,
   output logic [7:0]       stall_cnt,
   output logic             stall_timeout,
   output logic             state_err,
   output logic [31:0]      perf_stalls,
   output logic [31:0]      perf_flushes
);

   localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

   pipe_fsm_t fsm;
   logic      is_enable;
   logic      is_flush;
   logic      is_hold;

   assign is_enable = (state == PIPE_ENABLE);
   assign is_flush  = (state == PIPE_FLUSH);
   // the undefined encoding 2'b11 is treated like a stall
   assign is_hold   = !is_enable && !is_flush;

   assign dout_valid    = (fsm != EMPTY);
   assign stall_timeout = (stall_cnt >= LIMIT);

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         fsm        <= EMPTY;
         dout_instr <= '0;
         dout_data  <= '0;
         stall_cnt  <= '0;
         state_err  <= 1'b0;
      end else begin
         if (state == 2'b11)
            state_err <= 1'b1;
         if (is_flush) begin
            fsm        <= EMPTY;
            dout_instr <= '0;
            dout_data  <= '0;
            stall_cnt  <= '0;
         end else if (is_hold) begin
            if (fsm != EMPTY) begin
               fsm <= HELD;
               if (stall_cnt != 8'hFF)
                  stall_cnt <= stall_cnt + 8'd1;
            end else begin
               stall_cnt <= '0;
            end
         end else begin
            fsm        <= din_valid ? LIVE : EMPTY;
            dout_instr <= din_instr;
            dout_data  <= din_data;
            stall_cnt  <= '0;
         end
      end
   end

`ifdef PIPE_LATCH_PERF_EN
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         perf_stalls  <= '0;
         perf_flushes <= '0;
      end else begin
         if (is_hold && dout_valid)
            perf_stalls <= perf_stalls + 32'd1;
         if (is_flush)
            perf_flushes <= perf_flushes + 32'd1;
      end
   end
`else
   assign perf_stalls  = '0;
   assign perf_flushes = '0;
`endif

   pipe_fields_decode u_decode (
      .instr (dout_instr),
      .valid (dout_valid),
      .rs    (rs),
      .rt    (rt),
      .wsel  (wsel),
      .regwr (regwr)
   );

endmodule

// File: tb/tb_pipe_latch.sv
// Directed bench for pipe_latch: decode vector table plus stall/flush/illegal-state sequences.
module tb_pipe_latch;

   localparam int WIDTH = 64;

   logic             CLK = 1'b0;
   logic             nRST;
   logic [1:0]       state;
   logic [31:0]      din_instr;
   logic [WIDTH-1:0] din_data;
   logic             din_valid;
   logic [31:0]      dout_instr;
   logic [WIDTH-1:0] dout_data;
   logic             dout_valid;
   logic [4:0]       rs, rt, wsel;
   logic             regwr;
   logic [7:0]       stall_cnt;
   logic             stall_timeout;
   logic             state_err;
   logic [31:0]      perf_stalls;
   logic [31:0]      perf_flushes;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   pipe_latch #(.WIDTH(WIDTH), .STALL_LIMIT(16)) dut (
      .CLK(CLK), .nRST(nRST), .state(state),
      .din_instr(din_instr), .din_data(din_data), .din_valid(din_valid),
      .dout_instr(dout_instr), .dout_data(dout_data), .dout_valid(dout_valid),
      .rs(rs), .rt(rt), .wsel(wsel), .regwr(regwr),
      .stall_cnt(stall_cnt), .stall_timeout(stall_timeout), .state_err(state_err),
      .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
   );

   typedef struct {
      logic [31:0]      instr;
      logic [WIDTH-1:0] data;
      logic             valid;
      logic [4:0]       e_rs;
      logic [4:0]       e_rt;
      logic [4:0]       e_wsel;
      logic             e_regwr;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // inputs change at the falling edge; outputs sampled 1 time unit after the rising edge
   task automatic step(input logic rst_n, input logic [1:0] st, input logic [31:0] ins,
                       input logic [WIDTH-1:0] dat, input logic vld);
      @(negedge CLK);
      nRST = rst_n; state = st; din_instr = ins; din_data = dat; din_valid = vld;
      @(posedge CLK);
      #1;
   endtask

   localparam logic [31:0] ADD_I = 32'h012A4020;
   localparam logic [1:0]  EN = 2'd0, ST = 2'd1, FL = 2'd2, BAD = 2'd3;

   logic [31:0] exp_perf_fl;
   logic [31:0] exp_perf_st;

   initial begin
      vecs[0] = '{ADD_I,        64'h1111_0000_0000_0001, 1'b1, 5'd9,  5'd10, 5'd8,  1'b1};
      vecs[1] = '{32'h03E00008, 64'h2222_0000_0000_0002, 1'b1, 5'd31, 5'd0,  5'd0,  1'b0};
      vecs[2] = '{32'h0C000010, 64'h3333_0000_0000_0003, 1'b1, 5'd0,  5'd0,  5'd31, 1'b1};
      vecs[3] = '{32'h8CC50004, 64'h4444_0000_0000_0004, 1'b1, 5'd6,  5'd5,  5'd5,  1'b1};
      vecs[4] = '{32'h20200001, 64'h5555_0000_0000_0005, 1'b1, 5'd1,  5'd0,  5'd0,  1'b0};
      vecs[5] = '{32'h344700FF, 64'h6666_0000_0000_0006, 1'b1, 5'd2,  5'd7,  5'd7,  1'b1};
      vecs[6] = '{32'hAC830000, 64'h7777_0000_0000_0007, 1'b1, 5'd4,  5'd3,  5'd3,  1'b0};
      vecs[7] = '{ADD_I,        64'h8888_0000_0000_0008, 1'b0, 5'd9,  5'd10, 5'd8,  1'b0};
      vecs[8] = '{32'h10220003, 64'h9999_0000_0000_0009, 1'b1, 5'd1,  5'd2,  5'd2,  1'b0};

`ifdef PIPE_LATCH_PERF_EN
      exp_perf_fl = 32'd1;
      exp_perf_st = 32'd300;
`else
      exp_perf_fl = 32'd0;
      exp_perf_st = 32'd0;
`endif

      // reset dominates an ENABLE with a valid instruction
      nRST = 1'b0; state = EN; din_instr = ADD_I; din_data = 64'hFFFF; din_valid = 1'b1;
      step(1'b0, EN, ADD_I, 64'hDEAD_BEEF, 1'b1);
      step(1'b0, EN, ADD_I, 64'hDEAD_BEEF, 1'b1);
      check("rst_instr", 64'(dout_instr), 64'd0);
      check("rst_data", dout_data, 64'd0);
      check("rst_valid", 64'(dout_valid), 64'd0);
      check("rst_regwr", 64'(regwr), 64'd0);
      check("rst_cnt", 64'(stall_cnt), 64'd0);
      check("rst_err", 64'(state_err), 64'd0);
      check("rst_pstall", 64'(perf_stalls), 64'd0);
      check("rst_pflush", 64'(perf_flushes), 64'd0);

      for (int i = 0; i < 9; i++) begin
         step(1'b1, EN, vecs[i].instr, vecs[i].data, vecs[i].valid);
         check($sformatf("v%0d_instr", i), 64'(dout_instr), 64'(vecs[i].instr));
         check($sformatf("v%0d_data", i), dout_data, vecs[i].data);
         check($sformatf("v%0d_valid", i), 64'(dout_valid), 64'(vecs[i].valid));
         check($sformatf("v%0d_rs", i), 64'(rs), 64'(vecs[i].e_rs));
         check($sformatf("v%0d_rt", i), 64'(rt), 64'(vecs[i].e_rt));
         check($sformatf("v%0d_wsel", i), 64'(wsel), 64'(vecs[i].e_wsel));
         check($sformatf("v%0d_regwr", i), 64'(regwr), 64'(vecs[i].e_regwr));
         check($sformatf("v%0d_cnt", i), 64'(stall_cnt), 64'd0);
      end

      // long stall: hold, count, timeout at 16
      step(1'b1, EN, ADD_I, 64'hA5A5, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         step(1'b1, ST, 32'hFFFF_FFFF, 64'h0, 1'b0);
         check($sformatf("st%0d_cnt", i), 64'(stall_cnt), 64'(i));
         check($sformatf("st%0d_to", i), 64'(stall_timeout), (i >= 16) ? 64'd1 : 64'd0);
      end
      check("st_hold_instr", 64'(dout_instr), 64'(ADD_I));
      check("st_hold_data", dout_data, 64'hA5A5);
      check("st_hold_valid", 64'(dout_valid), 64'd1);
      check("st_hold_regwr", 64'(regwr), 64'd1);
      step(1'b1, EN, 32'h344700FF, 64'h5A5A, 1'b1);
      check("en_clr_cnt", 64'(stall_cnt), 64'd0);
      check("en_clr_to", 64'(stall_timeout), 64'd0);
      check("en_new_data", dout_data, 64'h5A5A);

      // held slot then flush
      step(1'b1, ST, 32'h0, 64'h0, 1'b0);
      check("held_cnt", 64'(stall_cnt), 64'd1);
      step(1'b1, FL, ADD_I, 64'h1234, 1'b1);
      check("fl_valid", 64'(dout_valid), 64'd0);
      check("fl_instr", 64'(dout_instr), 64'd0);
      check("fl_data", dout_data, 64'd0);
      check("fl_regwr", 64'(regwr), 64'd0);
      check("fl_cnt", 64'(stall_cnt), 64'd0);
      check("fl_perf", 64'(perf_flushes), 64'(exp_perf_fl));

      // stalling an empty slot keeps the count at 0
      step(1'b1, ST, ADD_I, 64'h1, 1'b1);
      check("empty_st_cnt", 64'(stall_cnt), 64'd0);
      check("empty_st_valid", 64'(dout_valid), 64'd0);

      // illegal state: acts as stall, sticky error
      step(1'b1, EN, ADD_I, 64'hBEEF, 1'b1);
      check("pre_bad_err", 64'(state_err), 64'd0);
      step(1'b1, BAD, 32'h0C000010, 64'h0, 1'b0);
      check("bad_instr", 64'(dout_instr), 64'(ADD_I));
      check("bad_data", dout_data, 64'hBEEF);
      check("bad_valid", 64'(dout_valid), 64'd1);
      check("bad_cnt", 64'(stall_cnt), 64'd1);
      check("bad_err", 64'(state_err), 64'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, EN, ADD_I, 64'(i), 1'b1);
         check($sformatf("err_sticky%0d", i), 64'(state_err), 64'd1);
      end

      // reset, then 300 stalls on a live slot
      step(1'b0, EN, ADD_I, 64'h0, 1'b1);
      check("rst2_err", 64'(state_err), 64'd0);
      check("rst2_valid", 64'(dout_valid), 64'd0);
      step(1'b1, EN, ADD_I, 64'hC0FFEE, 1'b1);
      for (int i = 1; i <= 300; i++) begin
         step(1'b1, ST, 32'h0, 64'h0, 1'b0);
         if (i == 255 || i == 256)
            check($sformatf("sat%0d_cnt", i), 64'(stall_cnt), 64'd255);
      end
      check("sat_cnt", 64'(stall_cnt), 64'd255);
      check("sat_to", 64'(stall_timeout), 64'd1);
      check("sat_data", dout_data, 64'hC0FFEE);
      check("sat_perf", 64'(perf_stalls), 64'(exp_perf_st));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
